// File: rtl/iter_muldiv_if.sv
//------------------------------------------------------------------------------
// iter_muldiv_if : start/busy/done handshake and HI/LO result bundle
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface iter_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo, div_zero
  );
endinterface

`default_nettype wire

// File: rtl/iter_muldiv.sv
//------------------------------------------------------------------------------
// iter_muldiv : iterative MULT/MULTU/DIV/DIVU unit producing a HI/LO pair
// Option MULDIV_FAST_MUL_EN: single-cycle combinational multiplier path
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module iter_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  wire logic    clock,
  input  wire logic    resetn,
  iter_muldiv_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] md_q, md_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             isdiv_q, isdiv_d;
  logic             negp_q, negp_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;

  logic               w_sgn;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_addend;
  logic [WIDTH:0]     w_mul_sum, w_shift, w_diff;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;

  assign w_sgn   = ~bus.op[0];
  assign w_abs_a = (w_sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_abs_b = (w_sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // rem_q doubles as the upper accumulator half during multiply
  assign w_addend   = quo_q[0] ? md_q : '0;
  assign w_mul_sum  = rem_q + {1'b0, w_addend};
  assign w_shift    = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, md_q};
  assign w_prod     = {rem_q[WIDTH-1:0], quo_q};
  assign w_prod_fix = negp_q ? -w_prod : w_prod;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_a, w_fast_b, w_fast_p;
  assign w_fast_a = {{WIDTH{w_sgn & bus.a[WIDTH-1]}}, bus.a};
  assign w_fast_b = {{WIDTH{w_sgn & bus.b[WIDTH-1]}}, bus.b};
  assign w_fast_p = w_fast_a * w_fast_b;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_d    = md_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    isdiv_d = isdiv_q;
    negp_d  = negp_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.cancel) begin
          cnt_d   = '0;
          dz_d    = 1'b0;
          isdiv_d = bus.op[1];
          negp_d  = w_sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          negr_d  = w_sgn && bus.a[WIDTH-1];
          rem_d   = '0;
          md_d    = bus.op[1] ? w_abs_b : w_abs_a;
          quo_d   = bus.op[1] ? w_abs_a : w_abs_b;
          if (bus.op[1] && (bus.b == '0)) begin
            state_d = S_DONE;
            lo_d    = '1;
            hi_d    = bus.a;
            dz_d    = 1'b1;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!bus.op[1]) begin
            state_d      = S_DONE;
            {hi_d, lo_d} = w_fast_p;
          end
`endif
          else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else begin
          if (isdiv_q) begin
            // restoring step: borrow out of the top bit means shifted < divisor
            rem_d = w_diff[WIDTH] ? w_shift : w_diff;
            quo_d = {quo_q[WIDTH-2:0], ~w_diff[WIDTH]};
          end else begin
            rem_d = {1'b0, w_mul_sum[WIDTH:1]};
            quo_d = {w_mul_sum[0], quo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          if (isdiv_q) begin
            lo_d = negp_q ? -quo_q : quo_q;
            hi_d = negr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          end else begin
            {hi_d, lo_d} = w_prod_fix;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      md_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      isdiv_q <= 1'b0;
      negp_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_q    <= md_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      isdiv_q <= isdiv_d;
      negp_q  <= negp_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy     = (state_q == S_RUN) || (state_q == S_FIX);
  assign bus.done     = (state_q == S_DONE);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_iter_muldiv.sv
//------------------------------------------------------------------------------
// tb_iter_muldiv : self-checking bench for iter_muldiv (random + directed)
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_iter_muldiv;
  localparam int W = 32;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 2;
`endif

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;

  iter_muldiv_if #(.WIDTH(W)) bus();
  iter_muldiv #(.WIDTH(W)) dut (.clock(clk), .resetn(rstn), .bus(bus));

  always #5 clk = ~clk;

  // Reference model straight from the arithmetic definitions
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] ehi, output logic [W-1:0] elo, output logic edz);
    longint sa, sb, q, r;
    logic [2*W-1:0] p;
    sa = $signed(a);
    sb = $signed(b);
    edz = 1'b0;
    ehi = '0;
    elo = '0;
    if (op[1] && b == '0) begin
      elo = '1; ehi = a; edz = 1'b1;
    end else if (op == 2'd0) begin
      p = 64'(sa * sb); {ehi, elo} = p;
    end else if (op == 2'd1) begin
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; {ehi, elo} = p;
    end else if (op == 2'd2) begin
      q = sa / sb; r = sa % sb;
      elo = q[W-1:0]; ehi = r[W-1:0];
    end else begin
      elo = a / b; ehi = a % b;
    end
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] b);
    if (op[1] && b == '0) return 1;
    if (op[1]) return W + 2;
    return MUL_LAT;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return MINV;
      2: return '1;
      3: return 1;
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Returns the start-to-done cycle count and how many cycles busy was high before done
  task automatic wait_done(output int lat, output int busy_n);
    lat = 1; busy_n = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    bus.start = 0; bus.cancel = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000 || bus.hi !== '0 || bus.lo !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h, required all 0",
               bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    vec_t v[$];
    int lat, bn, el;
    v.push_back('{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
    v.push_back('{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0});
    v.push_back('{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
    v.push_back('{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0});
    v.push_back('{2'd3, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1});
    v.push_back('{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
    v.push_back('{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0});
    foreach (v[i]) begin
      el = exp_lat(v[i].op, v[i].b);
      issue(v[i].op, v[i].a, v[i].b);
      wait_done(lat, bn);
      checks++;
      if (lat !== el || bn !== el - 1 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d latency: lat=%0d busy_cycles=%0d busy=%b, required lat=%0d busy_cycles=%0d busy=0",
                 i, lat, bn, bus.busy, el, el - 1);
      end
      checks++;
      if (bus.hi !== v[i].hi || bus.lo !== v[i].lo || bus.div_zero !== v[i].dz) begin
        errors++;
        $display("FAIL dir%0d result: hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=%b",
                 i, bus.hi, bus.lo, bus.div_zero, v[i].hi, v[i].lo, v[i].dz);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || bus.hi !== v[i].hi || bus.lo !== v[i].lo || bus.div_zero !== v[i].dz) begin
        errors++;
        $display("FAIL dir%0d hold: done=%b hi=%h lo=%h dz=%b, required done=0 hi=%h lo=%h dz=%b",
                 i, bus.done, bus.hi, bus.lo, bus.div_zero, v[i].hi, v[i].lo, v[i].dz);
      end
    end
  endtask

  // Each op issued in the IDLE cycle right after the previous DONE
  task automatic test_random_back_to_back();
    logic [1:0] op;
    logic [W-1:0] a, b, ehi, elo;
    logic edz;
    int lat, bn;
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      model(op, a, b, ehi, elo, edz);
      issue(op, a, b);
      wait_done(lat, bn);
      checks++;
      if (lat !== exp_lat(op, b) || bus.hi !== ehi || bus.lo !== elo || bus.div_zero !== edz) begin
        errors++;
        $display("FAIL rand%0d op=%0d a=%h b=%h: lat=%0d hi=%h lo=%h dz=%b, required lat=%0d hi=%h lo=%h dz=%b",
                 n, op, a, b, lat, bus.hi, bus.lo, bus.div_zero, exp_lat(op, b), ehi, elo, edz);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cancel();
    logic [W-1:0] phi, plo;
    logic pdz;
    int lat, bn, seen;
    phi = bus.hi; plo = bus.lo; pdz = bus.div_zero;
    issue(2'd3, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_busy: busy=%b, required 0", bus.busy);
    end
    seen = 0;
    repeat (W + 6) begin
      if (bus.done) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0 || bus.hi !== phi || bus.lo !== plo || bus.div_zero !== pdz) begin
      errors++;
      $display("FAIL cancel_hold: done_pulses=%0d hi=%h lo=%h dz=%b, required 0 %h %h %b",
               seen, bus.hi, bus.lo, bus.div_zero, phi, plo, pdz);
    end
    issue(2'd3, 32'd100, 32'd7);
    wait_done(lat, bn);
    checks++;
    if (!bus.done || bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      errors++;
      $display("FAIL cancel_retry: done=%b hi=%h lo=%h, required done=1 hi=2 lo=14", bus.done, bus.hi, bus.lo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cancel_idle();
    int seen;
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 2'd3; bus.a = 32'd9; bus.b = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.cancel = 1'b0;
    seen = 0;
    repeat (4) begin
      if (bus.done || bus.busy) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL cancel_idle: active_cycles=%0d, required 0", seen);
    end
  endtask

  task automatic test_start_while_busy();
    logic [W-1:0] a, b, ehi, elo;
    logic edz;
    int lat;
    a = $urandom;
    b = $urandom | 32'h1;
    model(2'd2, a, b, ehi, elo, edz);
    issue(2'd2, a, b);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 2'd1; bus.a = $urandom; bus.b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 8;
    while (!bus.done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== W + 2 || bus.hi !== ehi || bus.lo !== elo || bus.div_zero !== edz) begin
      errors++;
      $display("FAIL start_busy: lat=%0d hi=%h lo=%h dz=%b, required lat=%0d hi=%h lo=%h dz=%b",
               lat, bus.hi, bus.lo, bus.div_zero, W + 2, ehi, elo, edz);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, bn, seen;
    issue(2'd3, 32'hABCD1234, 32'd0);
    wait_done(lat, bn);
    @(posedge clk); #1;
    issue(2'd3, $urandom, $urandom | 32'h1);
    repeat (10) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    checks++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000 || bus.hi !== '0 || bus.lo !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b dz=%b hi=%h lo=%h, required all 0",
               bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo);
    end
    seen = 0;
    repeat (W + 6) begin
      if (bus.done || bus.busy) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: active_cycles=%0d, required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_back_to_back();
    test_cancel();
    test_cancel_idle();
    test_start_while_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iter_muldiv.md
Name: iter_muldiv

Overview:
- Multi-cycle integer multiply/divide unit for the EX stage of the pipelined CPU.
- Implements MULT, MULTU, DIV and DIVU and produces a HI/LO result pair.
- Replaces the undefined div/mod slots of the combinational ALU.
- Parametrised in operand width; uses a start/busy/done handshake with a pipeline cancel for interrupt flush.

Parameters:
- WIDTH, 32, operand width in bits (even, >= 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  synchronous active-low reset.
- start  in  1  request a new operation. Sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  multiplicand or dividend (rs).
- b  in  WIDTH  multiplier or divisor (rt).
- cancel  in  1  pipeline flush. Aborts the operation in flight.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse: hi/lo are valid this cycle.
- hi  out  WIDTH  product upper half, or remainder.
- lo  out  WIDTH  product lower half, or quotient.
- div_zero  out  1  sticky flag: last DIV/DIVU had b==0. Cleared on the next accepted start.

Behaviour:
- Reset: when resetn==0 at a clock edge, the following are cleared:
  - state=IDLE, busy=0, done=0, hi=0, lo=0, div_zero=0, counter=0.
  - Reset mid-operation aborts the operation with no done.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - On start=1 and cancel=0, latch op, the operand magnitudes, and the sign flags.
    - Signed ops (MULT, DIV) use |a| and |b|.
    - Unsigned ops use a and b as-is.
  - Clear counter and div_zero, then go to RUN. busy=1 from the next cycle.
  - Divide by zero: DIV/DIVU with b==0 skips RUN and goes directly to DONE with:
    - lo = all ones, hi = a, div_zero = 1.
- RUN: exactly WIDTH cycles, one bit per cycle.
  - Multiply: shift-add on a 2*WIDTH accumulator, LSB-first.
  - Divide: restoring division, MSB-first. Remainder register is WIDTH+1 bits; the quotient is shifted into the low register.
  - After the counter reaches WIDTH-1, go to FIX.
- FIX (1 cycle): sign correction for signed ops.
  - MULT: negate the 2*WIDTH product if sign(a) != sign(b).
  - DIV: negate the quotient if sign(a) != sign(b); the remainder takes the sign of a.
  - Load hi/lo, then go to DONE.
- DONE (1 cycle): done=1, busy=0. Next state is IDLE.
  - hi, lo and div_zero then hold their values until the next accepted start.
- Latency, start cycle to done cycle:
  - Normal operations: WIDTH+2 cycles (34 for WIDTH=32).
  - Divide by zero: 1 cycle.
- Signed overflow: DIV of MIN by -1 gives lo=MIN, hi=0. This is the natural result of the magnitude algorithm; no flag is raised.
- MIN as an operand: |MIN| = 2^(WIDTH-1) is valid as a WIDTH-bit unsigned magnitude, so no special case is needed.
- Start while busy=1: ignored, no effect on the operation in flight. The issuer stalls on busy.
- cancel:
  - In RUN or FIX: next state IDLE, busy=0, no done pulse, and hi/lo/div_zero keep their previous values.
  - In IDLE together with start: cancel wins and start is ignored.
  - In DONE: ignored, and done still pulses.
- Back-to-back: start is accepted in the IDLE cycle immediately after DONE, so the minimum issue interval is WIDTH+3 cycles.
- Arithmetic is modular; hi and lo never contain X.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU use a single-cycle combinational WIDTH x WIDTH multiplier (signed or unsigned per op).
  - The path is IDLE -> DONE, loading hi/lo directly, for a latency of 1 cycle.
  - DIV/DIVU are unchanged.
- Undefined: all operations take the iterative path described in Behaviour.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at start+34: hi=0xFFFFFFFE, lo=0x00000001. busy is high for 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
  - With MULDIV_FAST_MUL_EN: the same values, with done 1 cycle after start.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - DIVU with the same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
  - DIVU a=5, b=0 -> done 1 cycle later: lo=0xFFFFFFFF, hi=5, div_zero=1.
- Start DIVU 100/7, then assert cancel at cycle 10 -> busy drops, no done pulse, hi/lo keep their previous values.
  - Then issue a new start -> lo=14, hi=2.
- Assert start while busy -> ignored, and the original result is correct.
  - Pull resetn low mid-RUN -> all outputs are 0 the next cycle.
